csa_serial_resolver: RTL and testbench
======================================

// Module: csa_serial_resolver
// PURPOSE
//  Final carry-propagate stage after the 4:2 compressor / FA reduction tree of the 8-bit multiplier.
//  Takes the redundant (sum, carry) vectors from the tree and resolves them to a binary product.
//  Resolution is digit-serial: BPC bits per clock through a ripple chain of FA cells.
//  Valid/ready handshake on both sides; one operand pair in flight at a time.
// PARAMETERS
//  W        16  operand/result width (16 for 8x8 product)
//  BPC      1   bits resolved per clock; must divide W
//  APPROX_K 4   approximate LSB count (used only with CSA_APPROX_LSB_EN); multiple of BPC, < W
// PORTS
//  clk         in   1  clock, rising edge
//  rst         in   1  asynchronous reset, active-high
//  in_valid    in   1  sum/carry vectors valid
//  in_ready    out  1  block can accept (high only in IDLE)
//  in_sum      in   W  sum vector from reduction tree
//  in_carry    in   W  carry vector, already weight-aligned (no shift applied here)
//  out_valid   out  1  result valid
//  out_ready   in   1  consumer accepts result
//  out_result  out  W  (in_sum + in_carry) mod 2^W
//  out_cout    out  1  carry out of bit W-1
// BEHAVIOUR
//  - Reset (async, rst=1): state=IDLE, out_valid=0, out_result=0, out_cout=0, carry reg=0, digit counter=0; in_ready=1 once rst deasserts.
//  - FSM IDLE -> RUN -> DONE -> IDLE.
//  - IDLE: in_ready=1. On in_valid&&in_ready: latch in_sum/in_carry into shift regs, carry reg=0, cnt=0, go RUN.
//  - RUN: each cycle add lowest BPC bits of sum/carry regs plus carry reg through BPC-cell FA ripple;
//    shift results into out_result from MSB side, shift operands right by BPC, update carry reg, cnt++.
//    After W/BPC RUN cycles: out_cout=carry reg final, out_valid=1, go DONE.
//  - Latency: out_valid rises exactly W/BPC cycles after the accept edge (16 for defaults).
//  - DONE: out_valid=1, out_result/out_cout held stable until out_valid&&out_ready; then out_valid=0, go IDLE.
//  - No bypass: in_ready stays 0 during the DONE->IDLE handshake cycle; next accept no earlier than following cycle.
//  - in_valid ignored outside IDLE; input vectors need only be stable on the accept edge.
//  - out_result is not guaranteed meaningful while out_valid=0 (partially shifted contents).
//  - Reset mid-RUN or mid-DONE: operation discarded, all outputs to reset values, no output handshake.
//  - Wrap: overflow beyond W bits only reported on out_cout; out_result is modulo 2^W.
// CONFIGURATION
//  - Macro CSA_APPROX_LSB_EN defined: on accept, low APPROX_K result bits = in_sum|in_carry (no carry generated),
//    carry into bit APPROX_K forced 0, cnt starts at APPROX_K/BPC; latency = (W-APPROX_K)/BPC.
//  - Macro not defined: exact addition over all W bits; APPROX_K unused.
// STRUCTURE
//  - Shared package: FSM state enum (IDLE/RUN/DONE), counter width localparam $clog2(W/BPC+1), legality checks (W%BPC==0, APPROX_K%BPC==0).
//  - One sub-module: csa_digit_adder (BPC-bit ripple of existing FA cells, cin/cout), instantiated once.
//  - Top holds FSM, counter, shift registers, carry register, handshake logic.
// TESTING
//  - W=16,BPC=1: sum=0x00FF,carry=0x0001 -> out_result=0x0100,cout=0, out_valid 16 cycles after accept.
//  - W=16,BPC=1: sum=0xFFFF,carry=0x0001 -> out_result=0x0000,cout=1.
//  - Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid=1, out_result stable, in_ready=0 throughout; accept on cycle 6.
//  - Reset at RUN cycle 7 -> out_valid=0,out_result=0,in_ready=1 after release; subsequent 0x1234+0x4321 -> 0x5555.
//  - BPC=4: sum=0x8000,carry=0x8000 -> out_result=0x0000,cout=1, latency 4 cycles.
//  - CSA_APPROX_LSB_EN,K=4: sum=0x000F,carry=0x0001 -> out_result=0x000F (exact build 0x0010), latency 12.

Source files
------------

// File: rtl/csa_serial_resolver_pkg.sv
// csa_serial_resolver_pkg: shared FSM state type, sizing and parameter checks for the serial CSA resolver
package csa_serial_resolver_pkg;

    localparam int W_DEF        = 16;
    localparam int BPC_DEF      = 1;
    localparam int APPROX_K_DEF = 4;
    localparam int CNT_W_DEF    = $clog2(W_DEF / BPC_DEF + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } csa_state_t;

    function automatic int cnt_width(input int w, input int bpc);
        return $clog2(w / bpc + 1);
    endfunction

    function automatic bit params_ok(input int w, input int bpc, input int k);
        return (bpc > 0) && (w % bpc == 0) && (k % bpc == 0) && (k >= 0) && (k < w);
    endfunction

endpackage

// File: rtl/csa_digit_adder.sv
// csa_digit_adder: BPC-bit ripple of full-adder cells with carry in/out
module csa_digit_adder
    import csa_serial_resolver_pkg::*;
#(
    parameter int BPC = BPC_DEF
) (
    input  logic [BPC-1:0] i_a,
    input  logic [BPC-1:0] i_b,
    input  logic           i_cin,
    output logic [BPC-1:0] o_sum,
    output logic           o_cout
);

    logic [BPC:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar i = 0; i < BPC; i++) begin : g_fa
        assign o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
        assign w_c[i+1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end

    assign o_cout = w_c[BPC];

endmodule

// File: rtl/csa_serial_resolver.sv
// csa_serial_resolver: digit-serial carry-propagate resolution of (sum, carry) vectors with valid/ready on both sides.
// Optional macro CSA_APPROX_LSB_EN: low APPROX_K result bits become sum|carry with no carry into bit APPROX_K.
module csa_serial_resolver
    import csa_serial_resolver_pkg::*;
#(
    parameter int W        = W_DEF,
    parameter int BPC      = BPC_DEF,
    parameter int APPROX_K = APPROX_K_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_sum,
    input  logic [W-1:0] in_carry,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_result,
    output logic         out_cout
);

    localparam int CW = cnt_width(W, BPC);
    localparam logic [CW-1:0] LAST = CW'(W / BPC - 1);
`ifdef CSA_APPROX_LSB_EN
    localparam logic [CW-1:0] FIRST = CW'(APPROX_K / BPC);
`else
    localparam logic [CW-1:0] FIRST = '0;
`endif

    if (!params_ok(W, BPC, APPROX_K)) begin : g_bad_params
        $error("csa_serial_resolver: BPC must divide W and APPROX_K, APPROX_K < W");
    end

    csa_state_t     r_state;
    csa_state_t     w_next;
    logic [W-1:0]   r_sum;
    logic [W-1:0]   r_carry;
    logic [W-1:0]   r_res;
    logic           r_c;
    logic           r_cout;
    logic [CW-1:0]  r_cnt;
    logic [BPC-1:0] w_dsum;
    logic           w_dcout;
    logic           w_accept;
    logic           w_last;

    csa_digit_adder #(.BPC(BPC)) u_digit (
        .i_a    (r_sum[BPC-1:0]),
        .i_b    (r_carry[BPC-1:0]),
        .i_cin  (r_c),
        .o_sum  (w_dsum),
        .o_cout (w_dcout)
    );

    assign in_ready   = (r_state == S_IDLE) & ~rst;
    assign out_valid  = (r_state == S_DONE);
    assign out_result = r_res;
    assign out_cout   = r_cout;
    assign w_last     = (r_cnt == LAST);

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // next state and accept strobe
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_accept = in_valid & in_ready;
                w_next   = w_accept ? S_RUN : S_IDLE;
            end
            S_RUN:   w_next = w_last ? S_DONE : S_RUN;
            S_DONE:  w_next = out_ready ? S_IDLE : S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    // operand shift registers, ripple carry, result shift-in from the MSB side
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum   <= '0;
            r_carry <= '0;
            r_res   <= '0;
            r_c     <= 1'b0;
            r_cout  <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
`ifdef CSA_APPROX_LSB_EN
            r_sum   <= in_sum >> APPROX_K;
            r_carry <= in_carry >> APPROX_K;
            r_res   <= (in_sum | in_carry) << (W - APPROX_K);
`else
            r_sum   <= in_sum;
            r_carry <= in_carry;
            r_res   <= '0;
`endif
            r_c     <= 1'b0;
            r_cnt   <= FIRST;
        end else if (r_state == S_RUN) begin
            r_sum   <= r_sum >> BPC;
            r_carry <= r_carry >> BPC;
            r_res   <= W'({w_dsum, r_res} >> BPC);
            r_c     <= w_dcout;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) r_cout <= w_dcout;
        end
    end

endmodule

// File: tb/tb_csa_serial_resolver.sv
// tb_csa_serial_resolver: directed checks of the serial resolver (BPC=1 and BPC=4 instances)
module tb_csa_serial_resolver;

`ifdef CSA_APPROX_LSB_EN
    localparam int          LA  = 12;
    localparam int          LB  = 3;
    localparam logic [15:0] E1  = 16'h00FF;
    localparam logic [15:0] E2  = 16'hFFFF;
    localparam logic        E2C = 1'b0;
    localparam logic [15:0] E5  = 16'h000F;
`else
    localparam int          LA  = 16;
    localparam int          LB  = 4;
    localparam logic [15:0] E1  = 16'h0100;
    localparam logic [15:0] E2  = 16'h0000;
    localparam logic        E2C = 1'b1;
    localparam logic [15:0] E5  = 16'h0010;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_in_valid = 1'b0, a_out_ready = 1'b0;
    logic [15:0] a_sum = '0, a_carry = '0;
    logic        a_in_ready, a_out_valid, a_cout;
    logic [15:0] a_res;
    logic        b_in_valid = 1'b0, b_out_ready = 1'b0;
    logic [15:0] b_sum = '0, b_carry = '0;
    logic        b_in_ready, b_out_valid, b_cout;
    logic [15:0] b_res;
    int          n_pass = 0;
    int          n_tot = 0;
    int          lat;

    always #5 clk = ~clk;

    csa_serial_resolver #(.W(16), .BPC(1)) u_dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_sum(a_sum), .in_carry(a_carry),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_result(a_res), .out_cout(a_cout)
    );

    csa_serial_resolver #(.W(16), .BPC(4)) u_dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_sum(b_sum), .in_carry(b_carry),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_result(b_res), .out_cout(b_cout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_a(input logic [15:0] s, input logic [15:0] c, output int l);
        int guard = 0;
        while (!a_in_ready && guard < 50) begin
            tick();
            guard++;
        end
        a_sum      = s;
        a_carry    = c;
        a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        a_sum      = 16'hDEAD;
        a_carry    = 16'hBEEF;
        l = 0;
        while (!a_out_valid && l < 100) begin
            tick();
            l++;
        end
    endtask

    task automatic drain_a(input string tag);
        a_out_ready = 1'b1;
        chk({tag, "_hs_in_ready"}, a_in_ready, 0);
        tick();
        a_out_ready = 1'b0;
        chk({tag, "_drained_valid"}, a_out_valid, 0);
        chk({tag, "_idle_in_ready"}, a_in_ready, 1);
    endtask

    initial begin
        #1;
        chk("rst_out_valid", a_out_valid, 0);
        #12 rst = 1'b0;
        tick();
        chk("rst_in_ready", a_in_ready, 1);
        chk("rst_result", a_res, 0);
        chk("rst_cout", a_cout, 0);
        chk("rst_b_valid", b_out_valid, 0);

        run_a(16'h00FF, 16'h0001, lat);
        chk("op1_result", a_res, E1);
        chk("op1_cout", a_cout, 0);
        chk("op1_latency", lat, LA);
        drain_a("op1");

        run_a(16'hFFFF, 16'h0001, lat);
        chk("op2_result", a_res, E2);
        chk("op2_cout", a_cout, E2C);
        chk("op2_latency", lat, LA);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", a_out_valid, 1);
            chk("bp_result", a_res, E2);
            chk("bp_in_ready", a_in_ready, 0);
        end
        drain_a("bp");

        a_sum      = 16'h1111;
        a_carry    = 16'h2222;
        a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        repeat (7) tick();
        chk("mid_run_valid", a_out_valid, 0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", a_out_valid, 0);
        chk("mid_rst_result", a_res, 0);
        chk("mid_rst_cout", a_cout, 0);
        #3 rst = 1'b0;
        tick();
        chk("post_rst_in_ready", a_in_ready, 1);
        chk("post_rst_valid", a_out_valid, 0);

        run_a(16'h1234, 16'h4321, lat);
        chk("op4_result", a_res, 16'h5555);
        chk("op4_cout", a_cout, 0);
        chk("op4_latency", lat, LA);
        drain_a("op4");

        run_a(16'h000F, 16'h0001, lat);
        chk("op5_result", a_res, E5);
        chk("op5_latency", lat, LA);
        drain_a("op5");

        chk("b_in_ready", b_in_ready, 1);
        b_sum      = 16'h8000;
        b_carry    = 16'h8000;
        b_in_valid = 1'b1;
        tick();
        b_in_valid = 1'b0;
        lat = 0;
        while (!b_out_valid && lat < 100) begin
            tick();
            lat++;
        end
        chk("b_result", b_res, 16'h0000);
        chk("b_cout", b_cout, 1);
        chk("b_latency", lat, LB);
        b_out_ready = 1'b1;
        tick();
        b_out_ready = 1'b0;
        chk("b_drained_valid", b_out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
